// File: rtl/rx_ctrl_rcv.sv
// rtl/rx_ctrl_rcv.sv - 485 control link receiver: UART byte recovery and 6-byte command frame assembly
module rx_ctrl_rcv #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx_ctrl,
    input  logic [19:0] tbit_period,
    output logic [7:0]  cmdr_dev,
    output logic [7:0]  cmdr_mod,
    output logic [7:0]  cmdr_addr,
    output logic [7:0]  cmdr_data,
    output logic        cmdr_vld,
    output logic        err_frm,
    output logic        err_sum,
    output logic        err_tmo
);

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } bit_state_t;

    typedef enum logic [2:0] {
        F_HEAD,
        F_DEV,
        F_MOD,
        F_ADDR,
        F_DATA,
        F_SUM
    } frm_state_t;

    // Synchronizer and edge-detect history; all idle-high so reset never fakes a start edge
    logic rx_meta_q, rx_meta_d;
    logic rxs_q, rxs_d;
    logic rxs_prev_q, rxs_prev_d;

    // Bit recovery state
    bit_state_t  bit_state_q, bit_state_d;
    logic [19:0] bit_cnt_q, bit_cnt_d;
    logic [19:0] per_q, per_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;

    // Frame assembly state
    frm_state_t  frm_state_q, frm_state_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  sh_dev_q, sh_dev_d;
    logic [7:0]  sh_mod_q, sh_mod_d;
    logic [7:0]  sh_addr_q, sh_addr_d;
    logic [7:0]  sh_data_q, sh_data_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;

    // Registered outputs
    logic [7:0]  cmdr_dev_q, cmdr_dev_d;
    logic [7:0]  cmdr_mod_q, cmdr_mod_d;
    logic [7:0]  cmdr_addr_q, cmdr_addr_d;
    logic [7:0]  cmdr_data_q, cmdr_data_d;
    logic        cmdr_vld_q, cmdr_vld_d;
    logic        err_frm_q, err_frm_d;
    logic        err_sum_q, err_sum_d;
    logic        err_tmo_q, err_tmo_d;

    // Strobes from the bit FSM to the frame FSM, valid in the stop-sample cycle
    logic        fall_edge;
    logic        start_edge;
    logic        byte_ok;
    logic        stop_bad;
    logic [23:0] tmo_lim;

    assign fall_edge = rxs_prev_q & ~rxs_q;
    // Limit uses the period latched at the last start edge so it is stable between bytes
    assign tmo_lim   = 24'(TIMEOUT_BITS) * {4'd0, per_q};

    assign cmdr_dev  = cmdr_dev_q;
    assign cmdr_mod  = cmdr_mod_q;
    assign cmdr_addr = cmdr_addr_q;
    assign cmdr_data = cmdr_data_q;
    assign cmdr_vld  = cmdr_vld_q;
    assign err_frm   = err_frm_q;
    assign err_sum   = err_sum_q;
    assign err_tmo   = err_tmo_q;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_comb begin
        rx_meta_d  = rx_ctrl;
        rxs_d      = rx_meta_q;
        rxs_prev_d = rxs_q;
    end

    // Synchronizer registers, reset to the idle line level
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    // Bit FSM: find the start edge, sample mid-bit, shift data LSB first, check the stop bit
    always_comb begin
        bit_state_d = bit_state_q;
        bit_cnt_d   = bit_cnt_q;
        per_d       = per_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        start_edge  = 1'b0;
        byte_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (bit_state_q)
            B_IDLE: begin
                if (fall_edge) begin
                    start_edge  = 1'b1;
                    per_d       = tbit_period;
                    bit_cnt_d   = (tbit_period >> 1) - 20'd1;
                    bit_state_d = B_START;
                end
            end
            B_START: begin
                if (bit_cnt_q == 20'd0) begin
                    if (rxs_q) begin
                        // Line went back high before mid-bit: a glitch, not a start bit
                        bit_state_d = B_IDLE;
                    end else begin
                        bit_cnt_d   = per_q - 20'd1;
                        bit_idx_d   = 3'd0;
                        bit_state_d = B_DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 20'd1;
                end
            end
            B_DATA: begin
                if (bit_cnt_q == 20'd0) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = per_q - 20'd1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = B_STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 20'd1;
                end
            end
            B_STOP: begin
                if (bit_cnt_q == 20'd0) begin
                    byte_ok     = rxs_q;
                    stop_bad    = ~rxs_q;
                    bit_state_d = B_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 20'd1;
                end
            end
            default: begin
                bit_state_d = B_IDLE;
            end
        endcase
    end

    // Bit FSM registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= B_IDLE;
            bit_cnt_q   <= 20'd0;
            per_q       <= 20'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
        end else begin
            bit_state_q <= bit_state_d;
            bit_cnt_q   <= bit_cnt_d;
            per_q       <= per_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
        end
    end

    // Frame FSM: hunt for SYNC, collect four fields into shadows, verify the sum, watch the gap timer
    always_comb begin
        frm_state_d = frm_state_q;
        sum_d       = sum_q;
        sh_dev_d    = sh_dev_q;
        sh_mod_d    = sh_mod_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        tmo_cnt_d   = 24'd0;
        cmdr_dev_d  = cmdr_dev_q;
        cmdr_mod_d  = cmdr_mod_q;
        cmdr_addr_d = cmdr_addr_q;
        cmdr_data_d = cmdr_data_q;
        cmdr_vld_d  = 1'b0;
        err_frm_d   = 1'b0;
        err_sum_d   = 1'b0;
        err_tmo_d   = 1'b0;
        if (stop_bad) begin
            // A framing error drops any partial frame
            err_frm_d   = 1'b1;
            frm_state_d = F_HEAD;
        end else if (byte_ok) begin
            case (frm_state_q)
                F_HEAD: begin
                    if (shift_q == SYNC_BYTE) begin
                        sum_d       = 8'd0;
                        frm_state_d = F_DEV;
                    end
                end
                F_DEV: begin
                    sh_dev_d    = shift_q;
                    sum_d       = sum_q + shift_q;
                    frm_state_d = F_MOD;
                end
                F_MOD: begin
                    sh_mod_d    = shift_q;
                    sum_d       = sum_q + shift_q;
                    frm_state_d = F_ADDR;
                end
                F_ADDR: begin
                    sh_addr_d   = shift_q;
                    sum_d       = sum_q + shift_q;
                    frm_state_d = F_DATA;
                end
                F_DATA: begin
                    sh_data_d   = shift_q;
                    sum_d       = sum_q + shift_q;
                    frm_state_d = F_SUM;
                end
                F_SUM: begin
                    if (shift_q == sum_q) begin
                        cmdr_dev_d  = sh_dev_q;
                        cmdr_mod_d  = sh_mod_q;
                        cmdr_addr_d = sh_addr_q;
                        cmdr_data_d = sh_data_q;
                        cmdr_vld_d  = 1'b1;
                    end else begin
                        err_sum_d = 1'b1;
                    end
                    frm_state_d = F_HEAD;
                end
                default: begin
                    frm_state_d = F_HEAD;
                end
            endcase
        end else if ((frm_state_q != F_HEAD) && (bit_state_q == B_IDLE) && !start_edge) begin
            // Gap timer only runs while a frame is open and the line is between bytes
            if ((tmo_cnt_q + 24'd1) >= tmo_lim) begin
                err_tmo_d   = 1'b1;
                frm_state_d = F_HEAD;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 24'd1;
            end
        end
    end

    // Frame FSM and output registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            frm_state_q <= F_HEAD;
            sum_q       <= 8'd0;
            sh_dev_q    <= 8'd0;
            sh_mod_q    <= 8'd0;
            sh_addr_q   <= 8'd0;
            sh_data_q   <= 8'd0;
            tmo_cnt_q   <= 24'd0;
            cmdr_dev_q  <= 8'd0;
            cmdr_mod_q  <= 8'd0;
            cmdr_addr_q <= 8'd0;
            cmdr_data_q <= 8'd0;
            cmdr_vld_q  <= 1'b0;
            err_frm_q   <= 1'b0;
            err_sum_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            frm_state_q <= frm_state_d;
            sum_q       <= sum_d;
            sh_dev_q    <= sh_dev_d;
            sh_mod_q    <= sh_mod_d;
            sh_addr_q   <= sh_addr_d;
            sh_data_q   <= sh_data_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cmdr_dev_q  <= cmdr_dev_d;
            cmdr_mod_q  <= cmdr_mod_d;
            cmdr_addr_q <= cmdr_addr_d;
            cmdr_data_q <= cmdr_data_d;
            cmdr_vld_q  <= cmdr_vld_d;
            err_frm_q   <= err_frm_d;
            err_sum_q   <= err_sum_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

endmodule

// File: tb/tb_rx_ctrl_rcv.sv
// tb/tb_rx_ctrl_rcv.sv - directed bench for rx_ctrl_rcv
module tb_rx_ctrl_rcv;

    logic        clk_sys;
    logic        rst_n;
    logic        rx_ctrl;
    logic [19:0] tbit_period;
    logic [7:0]  cmdr_dev;
    logic [7:0]  cmdr_mod;
    logic [7:0]  cmdr_addr;
    logic [7:0]  cmdr_data;
    logic        cmdr_vld;
    logic        err_frm;
    logic        err_sum;
    logic        err_tmo;

    int checks;
    int errors;

    int cyc;
    int n_vld;
    int n_frm;
    int n_sum;
    int n_tmo;
    int n_multi;
    int tmo_cyc;

    int b_vld;
    int b_frm;
    int b_sum;
    int b_tmo;
    int t_end;

    rx_ctrl_rcv dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .rx_ctrl     (rx_ctrl),
        .tbit_period (tbit_period),
        .cmdr_dev    (cmdr_dev),
        .cmdr_mod    (cmdr_mod),
        .cmdr_addr   (cmdr_addr),
        .cmdr_data   (cmdr_data),
        .cmdr_vld    (cmdr_vld),
        .err_frm     (err_frm),
        .err_sum     (err_sum),
        .err_tmo     (err_tmo)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Pulse monitor, sampled on the falling edge away from the active edge
    initial begin
        cyc = 0; n_vld = 0; n_frm = 0; n_sum = 0; n_tmo = 0; n_multi = 0; tmo_cyc = 0;
    end
    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (cmdr_vld) n_vld = n_vld + 1;
        if (err_frm) n_frm = n_frm + 1;
        if (err_sum) n_sum = n_sum + 1;
        if (err_tmo) begin
            n_tmo   = n_tmo + 1;
            tmo_cyc = cyc;
        end
        if ((int'(err_frm) + int'(err_sum) + int'(err_tmo)) > 1) n_multi = n_multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic snap();
        b_vld = n_vld; b_frm = n_frm; b_sum = n_sum; b_tmo = n_tmo;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        rx_ctrl = 1'b0;
        wait_cycles(10);
        for (int i = 0; i < 8; i++) begin
            rx_ctrl = v[i];
            wait_cycles(10);
        end
        rx_ctrl = stop_bit;
        wait_cycles(10);
        rx_ctrl = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(b4, 1'b1);
        send_byte(b5, 1'b1);
        wait_cycles(30);
    endtask

    task automatic chk_out_zero(input string tag);
        chk({tag, "_dev"},  32'(cmdr_dev),  32'h0);
        chk({tag, "_mod"},  32'(cmdr_mod),  32'h0);
        chk({tag, "_addr"}, 32'(cmdr_addr), 32'h0);
        chk({tag, "_data"}, 32'(cmdr_data), 32'h0);
        chk({tag, "_vld"},  32'(cmdr_vld),  32'h0);
        chk({tag, "_efrm"}, 32'(err_frm),   32'h0);
        chk({tag, "_esum"}, 32'(err_sum),   32'h0);
        chk({tag, "_etmo"}, 32'(err_tmo),   32'h0);
    endtask

    task automatic chk_counts(input string tag, input int vld, input int frm, input int sum, input int tmo);
        chk({tag, "_nvld"}, 32'(n_vld - b_vld), 32'(vld));
        chk({tag, "_nfrm"}, 32'(n_frm - b_frm), 32'(frm));
        chk({tag, "_nsum"}, 32'(n_sum - b_sum), 32'(sum));
        chk({tag, "_ntmo"}, 32'(n_tmo - b_tmo), 32'(tmo));
    endtask

    task automatic chk_fields(input string tag, input logic [7:0] d, input logic [7:0] m,
                              input logic [7:0] a, input logic [7:0] x);
        chk({tag, "_dev"},  32'(cmdr_dev),  32'(d));
        chk({tag, "_mod"},  32'(cmdr_mod),  32'(m));
        chk({tag, "_addr"}, 32'(cmdr_addr), 32'(a));
        chk({tag, "_data"}, 32'(cmdr_data), 32'(x));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        rx_ctrl     = 1'b1;
        tbit_period = 20'd10;
        wait_cycles(5);
        chk_out_zero("reset");
        rst_n = 1'b1;
        wait_cycles(20);

        // 1: good frame
        snap();
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        chk_counts("t1", 1, 0, 0, 0);
        chk_fields("t1", 8'h01, 8'h02, 8'h03, 8'h04);

        // 2: bad checksum keeps previous fields
        snap();
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
        chk_counts("t2", 0, 0, 1, 0);
        chk_fields("t2", 8'h01, 8'h02, 8'h03, 8'h04);

        // 3: short glitch is not a start bit
        snap();
        rx_ctrl = 1'b0;
        wait_cycles(3);
        rx_ctrl = 1'b1;
        wait_cycles(200);
        chk_counts("t3", 0, 0, 0, 0);

        // 4: framing error mid-frame, then a good frame
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b0);
        wait_cycles(20);
        chk_counts("t4a", 0, 1, 0, 0);
        send_frame(8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
        chk_counts("t4b", 1, 1, 0, 0);
        chk_fields("t4", 8'h10, 8'h20, 8'h30, 8'h40);

        // 5: inter-byte timeout after 16 bit periods of idle, then a good frame
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        t_end = cyc;
        wait_cycles(1700);
        chk_counts("t5a", 0, 0, 0, 1);
        chk("t5_tmo_early", 32'((tmo_cyc - t_end) >= 150), 32'h1);
        chk("t5_tmo_late",  32'((tmo_cyc - t_end) <= 170), 32'h1);
        send_frame(8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        chk_counts("t5b", 1, 0, 0, 1);
        chk_fields("t5", 8'h11, 8'h22, 8'h33, 8'h44);

        // 6: reset mid-byte inside a frame, then a good all-FF frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        rx_ctrl = 1'b0;
        wait_cycles(25);
        rst_n = 1'b0;
        #2;
        chk_out_zero("t6_rst");
        wait_cycles(3);
        rx_ctrl = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        snap();
        wait_cycles(300);
        chk_counts("t6_idle", 0, 0, 0, 0);
        send_frame(8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC);
        chk_counts("t6", 1, 0, 0, 0);
        chk_fields("t6", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        chk("multi_err", 32'(n_multi), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
